// File: rtl/bridge_split_odd.sv
// Width-down bridge: wide beats of DIN_W lanes in, narrow beats of DOUT_W out.
// Residual lanes carry across input beats; the packet tail leaves zero-padded.
module bridge_split_odd #(
   parameter int DIN_W     = 32,
   parameter int DOUT_W    = 3,
   parameter int DATA_W    = 8,
   parameter int REG_W     = DIN_W + DOUT_W,
   parameter int CNT_WIDTH = $clog2(REG_W + 1),
   parameter int KEEP_W    = $clog2(DOUT_W + 1)
) (
   input  logic                           clk,
   input  logic                           a_rst,
   input  logic                           vld_i,
   input  logic [DIN_W-1:0][DATA_W-1:0]   din,
   input  logic                           last_i,
   output logic                           rdy_o,
   output logic                           vld_o,
   output logic [DOUT_W-1:0][DATA_W-1:0]  dout,
   output logic [KEEP_W-1:0]              cnt_o,
   output logic                           last_o,
   input  logic                           rdy_i
);

   localparam int RB = REG_W * DATA_W;
   localparam logic [CNT_WIDTH-1:0] OUT_N = CNT_WIDTH'(DOUT_W);
   localparam logic [CNT_WIDTH-1:0] IN_N  = CNT_WIDTH'(DIN_W);

   typedef enum logic [1:0] {
      IDLE,
      NEED,
      DRAIN,
      TAIL
   } state_e;

   state_e               state_q, state_d;
   logic [RB-1:0]        reg_q, reg_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 last_q, last_d;

   logic [CNT_WIDTH-1:0] take, pop, rem;
   logic [RB-1:0]        din_ext;
   logic                 out_fire, in_fire;
   int                   pop_sh, rem_sh;

   // Occupancy, lane store, tail flag and derived state register
   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         state_q <= IDLE;
         reg_q   <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         reg_q   <= reg_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   // Handshakes, outputs and next state; pop is applied before the append
   always_comb begin
      take     = (cnt_q < OUT_N) ? cnt_q : OUT_N;
      din_ext  = RB'(din);
      vld_o    = (state_q == DRAIN) ||
                 ((state_q == TAIL) && (cnt_q != '0));
      last_o   = vld_o && (state_q == TAIL) && (cnt_q <= OUT_N);
      cnt_o    = vld_o ? KEEP_W'(take) : '0;
      dout     = reg_q[DOUT_W*DATA_W-1:0];
      out_fire = vld_o && rdy_i;
      pop      = out_fire ? take : '0;
      rem      = cnt_q - pop;
      rdy_o    = (state_q != TAIL) && (rem < OUT_N);
      in_fire  = vld_i && rdy_o;
      pop_sh   = int'(pop) * DATA_W;
      rem_sh   = int'(rem) * DATA_W;

      reg_d = reg_q >> pop_sh;
      if (in_fire) begin
         reg_d = reg_d | (din_ext << rem_sh);
      end
      cnt_d = rem + (in_fire ? IN_N : '0);

      last_d = last_q;
      if (in_fire && last_i) begin
         last_d = 1'b1;
      end
      if (out_fire && last_o) begin
         last_d = 1'b0;
      end

      if (last_d) begin
         state_d = TAIL;
      end else if (cnt_d == '0) begin
         state_d = IDLE;
      end else if (cnt_d < OUT_N) begin
         state_d = NEED;
      end else begin
         state_d = DRAIN;
      end
   end

endmodule

// File: tb/tb_bridge_split_odd.sv
// Directed and random-stall bench for bridge_split_odd.
// A second instance covers the exact-multiple (6 -> 3) tail case.
module tb_bridge_split_odd;

   logic             clk = 1'b0;
   logic             a_rst;
   logic             vld_i, last_i, rdy_i;
   logic [31:0][7:0] din;
   logic             rdy_o, vld_o, last_o;
   logic [2:0][7:0]  dout;
   logic [1:0]       cnt_o;

   logic             vld6, last6, rdy6_i;
   logic [5:0][7:0]  din6;
   logic             rdy6_o, vld6_o, last6_o;
   logic [2:0][7:0]  dout6;
   logic [1:0]       cnt6_o;

   int errs = 0;
   int checks = 0;

   bridge_split_odd u_dut (
      .clk   (clk),
      .a_rst (a_rst),
      .vld_i (vld_i),
      .din   (din),
      .last_i(last_i),
      .rdy_o (rdy_o),
      .vld_o (vld_o),
      .dout  (dout),
      .cnt_o (cnt_o),
      .last_o(last_o),
      .rdy_i (rdy_i)
   );

   bridge_split_odd #(.DIN_W(6), .DOUT_W(3), .DATA_W(8)) u_dut6 (
      .clk   (clk),
      .a_rst (a_rst),
      .vld_i (vld6),
      .din   (din6),
      .last_i(last6),
      .rdy_o (rdy6_o),
      .vld_o (vld6_o),
      .dout  (dout6),
      .cnt_o (cnt6_o),
      .last_o(last6_o),
      .rdy_i (rdy6_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] exp_beat(input int first, input int n);
      logic [23:0] r;
      r = '0;
      for (int j = 0; j < 3; j++) begin
         if (j < n) r[j*8 +: 8] = 8'(first + j);
      end
      return r;
   endfunction

   // single last beat of lanes base..base+31; returns after beat stop_after
   task automatic run_single(input int base, input int stop_after);
      int n;
      for (int i = 0; i < 32; i++) din[i] = 8'(base + i);
      vld_i = 1'b1;
      last_i = 1'b1;
      rdy_i = 1'b1;
      @(negedge clk);
      chk("s_rdy_accept", 64'(rdy_o), 64'd1);
      @(posedge clk); #1;
      vld_i = 1'b0;
      last_i = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         n = (k == 11) ? 2 : 3;
         @(negedge clk);
         chk("s_vld", 64'(vld_o), 64'd1);
         chk("s_dout", 64'(dout), 64'(exp_beat(base + 3*(k-1), n)));
         chk("s_cnt", 64'(cnt_o), 64'(n));
         chk("s_last", 64'(last_o), 64'(k == 11));
         chk("s_rdy_blocked", 64'(rdy_o), 64'd0);
         @(posedge clk); #1;
         if (k == stop_after) return;
      end
      @(negedge clk);
      chk("s_idle_vld", 64'(vld_o), 64'd0);
      chk("s_idle_rdy", 64'(rdy_o), 64'd1);
      @(posedge clk); #1;
   endtask

   // random-phase scoreboard
   logic [7:0] exp_q[$];
   int         len_q[$];
   bit         mon_en = 1'b0;
   int         emitted = 0;
   int         pkt_acc = 0;
   int         last_cnt = 0;

   // compare every output beat against the queued input lanes
   always @(negedge clk) begin
      int rp;
      int ec;
      bit el;
      logic [23:0] eb;
      if (mon_en) begin
         if (vld_o && rdy_i) begin
            rp = (len_q.size() != 0) ? len_q[0] - emitted : 3;
            ec = (rp < 3) ? rp : 3;
            el = (len_q.size() != 0) && (rp <= 3);
            eb = '0;
            for (int j = 0; j < 3; j++) begin
               if (j < ec) begin
                  if (exp_q.size() == 0) chk("rnd_underflow", 64'd1, 64'd0);
                  else eb[j*8 +: 8] = exp_q.pop_front();
               end
            end
            chk("rnd_dout", 64'(dout), 64'(eb));
            chk("rnd_cnt", 64'(cnt_o), 64'(ec));
            chk("rnd_last", 64'(last_o), 64'(el));
            emitted += ec;
            if (el) begin
               len_q.delete(0);
               emitted = 0;
               last_cnt++;
            end
         end
         if (vld_i && rdy_o) begin
            for (int i = 0; i < 32; i++) exp_q.push_back(din[i]);
            pkt_acc += 32;
            if (last_i) begin
               len_q.push_back(pkt_acc);
               pkt_acc = 0;
            end
         end
      end
   end

   int  cyc;
   bit  to;
   bit  acc;
   int  nb;
   int  n;
   logic [7:0] lane_ctr;

   task automatic step();
      @(posedge clk); #1;
      rdy_i = ($urandom % 4) != 0;
      cyc++;
      if (cyc > 90000) to = 1'b1;
   endtask

   initial begin
      a_rst = 1'b1;
      vld_i = 1'b0; last_i = 1'b0; rdy_i = 1'b1; din = '0;
      vld6 = 1'b0; last6 = 1'b0; rdy6_i = 1'b1; din6 = '0;
      #3;
      chk("rst_vld", 64'(vld_o), 64'd0);
      chk("rst_rdy", 64'(rdy_o), 64'd1);
      chk("rst_cnt", 64'(cnt_o), 64'd0);
      chk("rst_last", 64'(last_o), 64'd0);
      chk("rst_dout", 64'(dout), 64'd0);
      chk("rst_rdy6", 64'(rdy6_o), 64'd1);
      @(posedge clk);
      @(posedge clk); #1;
      a_rst = 1'b0;

      // 32 lanes in one last beat -> 11 beats
      run_single(0, 11);

      // A (0..31) then B (32..63, last) with a 5-cycle stall at beat 5
      for (int i = 0; i < 32; i++) din[i] = 8'(i);
      vld_i = 1'b1;
      last_i = 1'b0;
      rdy_i = 1'b1;
      @(negedge clk);
      chk("t2_rdy_a", 64'(rdy_o), 64'd1);
      @(posedge clk); #1;
      for (int i = 0; i < 32; i++) din[i] = 8'(32 + i);
      last_i = 1'b1;
      for (int k = 1; k <= 22; k++) begin
         n = (64 - 3*(k-1) < 3) ? 64 - 3*(k-1) : 3;
         if (k == 5) begin
            rdy_i = 1'b0;
            for (int s = 0; s < 5; s++) begin
               @(negedge clk);
               chk("bp_vld", 64'(vld_o), 64'd1);
               chk("bp_dout", 64'(dout), 64'(exp_beat(12, 3)));
               chk("bp_cnt", 64'(cnt_o), 64'd3);
               chk("bp_last", 64'(last_o), 64'd0);
               @(posedge clk); #1;
            end
            rdy_i = 1'b1;
         end
         @(negedge clk);
         chk("t2_vld", 64'(vld_o), 64'd1);
         chk("t2_dout", 64'(dout), 64'(exp_beat(3*(k-1), n)));
         chk("t2_cnt", 64'(cnt_o), 64'(n));
         chk("t2_last", 64'(last_o), 64'(k == 22));
         chk("t2_rdy", 64'(rdy_o), 64'(k == 10));
         @(posedge clk); #1;
         if (k == 10) begin
            vld_i = 1'b0;
            last_i = 1'b0;
         end
      end
      @(negedge clk);
      chk("t2_idle_vld", 64'(vld_o), 64'd0);
      chk("t2_idle_rdy", 64'(rdy_o), 64'd1);
      @(posedge clk); #1;

      // exact multiple: 6 lanes -> two full beats
      for (int i = 0; i < 6; i++) din6[i] = 8'(10 + i);
      vld6 = 1'b1;
      last6 = 1'b1;
      @(negedge clk);
      chk("x6_rdy", 64'(rdy6_o), 64'd1);
      @(posedge clk); #1;
      vld6 = 1'b0;
      last6 = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("x6_vld", 64'(vld6_o), 64'd1);
         chk("x6_dout", 64'(dout6), 64'(exp_beat(10 + 3*k, 3)));
         chk("x6_cnt", 64'(cnt6_o), 64'd3);
         chk("x6_last", 64'(last6_o), 64'(k == 1));
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("x6_idle", 64'(vld6_o), 64'd0);
      @(posedge clk); #1;

      // reset after beat 4, then a fresh packet
      run_single(0, 4);
      a_rst = 1'b1;
      #1;
      chk("mr_vld", 64'(vld_o), 64'd0);
      chk("mr_rdy", 64'(rdy_o), 64'd1);
      chk("mr_cnt", 64'(cnt_o), 64'd0);
      chk("mr_last", 64'(last_o), 64'd0);
      @(posedge clk); #1;
      a_rst = 1'b0;
      @(negedge clk);
      chk("mr_post_vld", 64'(vld_o), 64'd0);
      @(posedge clk); #1;
      run_single(100, 11);

      // random vld_i / rdy_i over 1000 packets
      mon_en = 1'b1;
      cyc = 0;
      to = 1'b0;
      lane_ctr = 8'd0;
      for (int p = 0; p < 1000 && !to; p++) begin
         nb = $urandom_range(1, 2);
         for (int b = 0; b < nb && !to; b++) begin
            for (int i = 0; i < 32; i++) begin
               din[i] = lane_ctr;
               lane_ctr = lane_ctr + 8'd1;
            end
            last_i = (b == nb - 1);
            acc = 1'b0;
            while (!acc && !to) begin
               vld_i = ($urandom % 4) != 0;
               @(negedge clk);
               acc = vld_i && rdy_o;
               step();
            end
         end
      end
      vld_i = 1'b0;
      last_i = 1'b0;
      while (last_cnt < 1000 && !to) step();
      mon_en = 1'b0;
      chk("rnd_timeout", 64'(to), 64'd0);
      chk("rnd_pkts", 64'(last_cnt), 64'd1000);
      chk("rnd_left", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
